// File: rtl/lab1_vector_checker_pkg.sv
// Shared definitions for the lab1 vector checker: FSM state encoding,
// default parameter values and small elaboration-time helpers.
package lab1_vector_checker_pkg;

    // FSM states of the checker.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Defaults match the 3-input lab1 function (majority) held 20 clocks per vector.
    localparam int unsigned DEFAULT_N_IN        = 32'd3;
    localparam int unsigned DEFAULT_HOLD_CYCLES = 32'd20;
    localparam logic [7:0]  DEFAULT_EXP_TABLE   = 8'b1110_1000;

    // Width of the hold counter; a one-clock hold still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned hold);
        int unsigned w;
        if (hold > 32'd1) begin
            w = $clog2(hold);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lab1_vector_checker_hold_timer.sv
// Hold timer: counts clocks while enabled and flags the last clock of each
// hold period. Wraps to zero on expiry so back-to-back holds need no reload.
module lab1_vector_checker_hold_timer
    import lab1_vector_checker_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    localparam int unsigned CNT_W      = cnt_width(HOLD_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             expire_s;

    assign expire_s = (cnt_r == LAST_CNT);
    assign cnt      = cnt_r;
    assign expire   = expire_s;

    // Next count: load clears, enable advances and wraps at the end of a hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (enable) begin
            if (expire_s) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/lab1_vector_checker.sv
// Exhaustive truth-table checker for the lab1 DUT. Walks every input vector
// in ascending order, holds each for HOLD_CYCLES clocks, samples the DUT
// output on the last clock of the hold and records mismatches against
// EXP_TABLE. Results stay frozen in DONE until the next start or reset.
module lab1_vector_checker
    import lab1_vector_checker_pkg::*;
#(
    parameter int unsigned            N_IN        = DEFAULT_N_IN,
    parameter int unsigned            HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter logic [(2**N_IN)-1:0]   EXP_TABLE   = DEFAULT_EXP_TABLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dut_o,
    output logic [N_IN-1:0]         vec,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(2**N_IN)-1:0]    mismatch_mask,
    output logic [N_IN:0]           err_count
);

    localparam int unsigned      N_VEC    = 2**N_IN;
    localparam int unsigned      CNT_W    = cnt_width(HOLD_CYCLES);
    localparam int unsigned      ERR_W    = N_IN + 32'd1;
    localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(N_VEC - 32'd1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [N_IN-1:0]     vec_r;
    logic [N_IN-1:0]     vec_nxt_s;
    logic [N_VEC-1:0]    mask_r;
    logic [N_VEC-1:0]    mask_nxt_s;
    logic [ERR_W-1:0]    err_r;
    logic [ERR_W-1:0]    err_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;
    logic                done_r;
    logic                done_nxt_s;
    logic                pass_r;
    logic                pass_nxt_s;

    logic                timer_load_s;
    logic                timer_en_s;
    logic [CNT_W-1:0]    hold_cnt_s;
    logic                expire_s;
    logic                mismatch_s;
    logic                unused_hold_cnt_s;

    // Per-vector hold timing lives in its own block; only the expiry strobe steers the FSM.
    lab1_vector_checker_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load_s),
        .enable (timer_en_s),
        .cnt    (hold_cnt_s),
        .expire (expire_s)
    );

    // The running count is kept visible for debug but not needed for control.
    assign unused_hold_cnt_s = ^hold_cnt_s;

    // Case-inequality so an X/Z from the DUT in simulation is reported as a mismatch.
    assign mismatch_s = (dut_o !== EXP_TABLE[vec_r]);

    assign vec           = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign mismatch_mask = mask_r;
    assign err_count     = err_r;

    // Next-state and result update logic for the IDLE/DRIVE/DONE walk.
    always_comb begin
        state_nxt_s  = state_r;
        vec_nxt_s    = vec_r;
        mask_nxt_s   = mask_r;
        err_nxt_s    = err_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = done_r;
        pass_nxt_s   = pass_r;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                // A start here begins a fresh run; DONE results are discarded.
                if (start) begin
                    state_nxt_s  = ST_DRIVE;
                    vec_nxt_s    = {N_IN{1'b0}};
                    mask_nxt_s   = {N_VEC{1'b0}};
                    err_nxt_s    = {ERR_W{1'b0}};
                    busy_nxt_s   = 1'b1;
                    done_nxt_s   = 1'b0;
                    pass_nxt_s   = 1'b0;
                    timer_load_s = 1'b1;
                end else begin
                    state_nxt_s  = state_r;
                end
            end

            ST_DRIVE: begin
                // start is deliberately not looked at while a run is in progress.
                timer_en_s = 1'b1;
                if (expire_s) begin
                    if (mismatch_s) begin
                        mask_nxt_s = mask_r | (N_VEC'(1'b1) << vec_r);
                        err_nxt_s  = err_r + ERR_W'(1'b1);
                    end else begin
                        mask_nxt_s = mask_r;
                        err_nxt_s  = err_r;
                    end
                    // The walk ends on the top vector; vec never wraps.
                    if (vec_r == LAST_VEC) begin
                        state_nxt_s = ST_DONE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_r == {ERR_W{1'b0}}) && !mismatch_s;
                    end else begin
                        vec_nxt_s   = vec_r + N_IN'(1'b1);
                    end
                end else begin
                    vec_nxt_s = vec_r;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_nxt_s = ST_IDLE;
                vec_nxt_s   = {N_IN{1'b0}};
                mask_nxt_s  = {N_VEC{1'b0}};
                err_nxt_s   = {ERR_W{1'b0}};
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
                pass_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset overrides everything, including a run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            vec_r   <= {N_IN{1'b0}};
            mask_r  <= {N_VEC{1'b0}};
            err_r   <= {ERR_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            vec_r   <= vec_nxt_s;
            mask_r  <= mask_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            pass_r  <= pass_nxt_s;
        end
    end

endmodule

// File: tb/tb_lab1_vector_checker.sv
// Self-checking bench for lab1_vector_checker: one instance with a 20-clock
// hold driven by a majority DUT (optionally stuck at 0), one instance with a
// 1-clock hold whose DUT is wrong only on vector 5. Expected vector steps and
// final results are queued at start and checked as the checker produces them.
module tb_lab1_vector_checker;

    localparam logic [7:0] EXP = 8'b1110_1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       dut_o0, dut_o1;
    logic [2:0] vec0, vec1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] mask0, mask1;
    logic [3:0] err0, err1;

    logic [2:0] c_vec;
    logic       c_busy, c_done, c_pass;
    logic [7:0] c_mask;
    logic [3:0] c_err;

    int sel = 0;
    int fault_mode = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { int vec; int at; } vec_ev_t;
    typedef struct { logic [7:0] mask; logic [3:0] err; logic pass; int at; } res_t;
    vec_ev_t vec_q[$];
    res_t    res_q[$];

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
    endfunction

    // Behaviour of the device under test attached to each checker.
    function automatic logic stub_o(input int s, input int f, input logic [2:0] v);
        if (s == 0) return (f == 0) ? maj(v) : 1'b0;
        return maj(v) ^ (v == 3'd5);
    endfunction

    always_comb dut_o0 = stub_o(0, fault_mode, vec0);
    always_comb dut_o1 = stub_o(1, 0, vec1);

    always_comb begin
        if (sel == 0) begin
            c_vec = vec0; c_busy = busy0; c_done = done0; c_pass = pass0; c_mask = mask0; c_err = err0;
        end else begin
            c_vec = vec1; c_busy = busy1; c_done = done1; c_pass = pass1; c_mask = mask1; c_err = err1;
        end
    end

    lab1_vector_checker #(.N_IN(3), .HOLD_CYCLES(20), .EXP_TABLE(EXP)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_o(dut_o0), .vec(vec0), .busy(busy0),
        .done(done0), .pass(pass0), .mismatch_mask(mask0), .err_count(err0)
    );

    lab1_vector_checker #(.N_IN(3), .HOLD_CYCLES(1), .EXP_TABLE(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_o(dut_o1), .vec(vec1), .busy(busy1),
        .done(done1), .pass(pass1), .mismatch_mask(mask1), .err_count(err1)
    );

    // Queue the expected run, pulse start and check the state right after acceptance.
    task automatic launch(input int s, input int h);
        res_t r;
        int e;
        logic [7:0] tbl;
        tbl = EXP;
        r.mask = 8'h00;
        e = 0;
        vec_q.delete();
        res_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (stub_o(s, fault_mode, 3'(i)) !== tbl[i]) begin
                r.mask[i] = 1'b1;
                e++;
            end
            if (i > 0) vec_q.push_back('{vec: i, at: i * h});
        end
        r.err = 4'(e);
        r.pass = (e == 0);
        r.at = 8 * h;
        res_q.push_back(r);
        sel = s;
        @(negedge clk);
        if (s == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        n_cmp++;
        if (c_busy !== 1'b1 || c_done !== 1'b0 || c_vec !== 3'd0 || c_mask !== 8'h00 || c_err !== 4'd0 || c_pass !== 1'b0)
            begin n_fail++; $display("FAIL start_accept: busy=%b done=%b vec=%0d mask=%b err=%0d pass=%b, required 1 0 0 00000000 0 0", c_busy, c_done, c_vec, c_mask, c_err, c_pass); end
    endtask

    // Follow a run to completion, popping expected vector steps and the final result.
    task automatic follow(input int h, input int poke_at);
        int prev;
        bit fin;
        res_t r;
        vec_ev_t ev;
        prev = int'(c_vec);
        fin = 1'b0;
        for (int j = 1; j <= 8 * h + 10 && !fin; j++) begin
            @(posedge clk);
            #1;
            if (int'(c_vec) != prev) begin
                n_cmp++;
                if (vec_q.size() == 0) begin
                    n_fail++; $display("FAIL vec_step: unexpected vec=%0d at clk %0d, no step required", c_vec, j);
                end else begin
                    ev = vec_q.pop_front();
                    if (c_vec !== 3'(ev.vec) || j != ev.at)
                        begin n_fail++; $display("FAIL vec_step: vec=%0d at clk %0d, required vec=%0d at clk %0d", c_vec, j, ev.vec, ev.at); end
                end
                prev = int'(c_vec);
            end
            if (c_done === 1'b1) begin
                fin = 1'b1;
                r = res_q.pop_front();
                n_cmp++;
                if (j != r.at) begin n_fail++; $display("FAIL done_time: done at clk %0d, required %0d", j, r.at); end
                n_cmp++;
                if (c_mask !== r.mask) begin n_fail++; $display("FAIL mask: got %b, required %b", c_mask, r.mask); end
                n_cmp++;
                if (c_err !== r.err) begin n_fail++; $display("FAIL err_count: got %0d, required %0d", c_err, r.err); end
                n_cmp++;
                if (c_pass !== r.pass) begin n_fail++; $display("FAIL pass: got %b, required %b", c_pass, r.pass); end
                n_cmp++;
                if (c_busy !== 1'b0 || c_vec !== 3'd7) begin n_fail++; $display("FAIL end_state: busy=%b vec=%0d, required busy=0 vec=7", c_busy, c_vec); end
                n_cmp++;
                if (vec_q.size() != 0) begin n_fail++; $display("FAIL missed_steps: %0d vector steps never seen, required 0", vec_q.size()); end
            end else begin
                n_cmp++;
                if (c_busy !== 1'b1 || c_pass !== 1'b0)
                    begin n_fail++; $display("FAIL busy_run: busy=%b pass=%b at clk %0d, required busy=1 pass=0", c_busy, c_pass, j); end
            end
            if (j == poke_at) begin
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        if (!fin) begin n_cmp++; n_fail++; $display("FAIL timeout: done not seen within %0d clocks", 8 * h + 10); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({vec0, busy0, done0, pass0, mask0, err0} !== 18'd0)
            begin n_fail++; $display("FAIL reset0: vec=%0d busy=%b done=%b pass=%b mask=%b err=%0d, required all 0", vec0, busy0, done0, pass0, mask0, err0); end
        n_cmp++;
        if ({vec1, busy1, done1, pass1, mask1, err1} !== 18'd0)
            begin n_fail++; $display("FAIL reset1: vec=%0d busy=%b done=%b pass=%b mask=%b err=%0d, required all 0", vec1, busy1, done1, pass1, mask1, err1); end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0)
            begin n_fail++; $display("FAIL start_in_reset: busy0=%b busy1=%b done0=%b, required 0 0 0", busy0, busy1, done0); end
    endtask

    task automatic test_golden();
        fault_mode = 0;
        launch(0, 20);
        follow(20, -1);
    endtask

    task automatic test_faulty();
        fault_mode = 1;
        launch(0, 20);
        follow(20, -1);
    endtask

    task automatic test_abort();
        fault_mode = 0;
        launch(0, 20);
        repeat (65) @(posedge clk);
        #1;
        n_cmp++;
        if (vec0 !== 3'd3) begin n_fail++; $display("FAIL abort_vec: vec=%0d before abort, required 3", vec0); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({vec0, busy0, done0, pass0, mask0, err0} !== 18'd0)
            begin n_fail++; $display("FAIL abort_clear: vec=%0d busy=%b done=%b pass=%b mask=%b err=%0d, required all 0", vec0, busy0, done0, pass0, mask0, err0); end
        rst = 1'b0;
        vec_q.delete();
        res_q.delete();
        launch(0, 20);
        follow(20, -1);
    endtask

    task automatic test_restart();
        fault_mode = 0;
        launch(0, 20);
        follow(20, 50);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0)
            begin n_fail++; $display("FAIL done_hold: done=%b pass=%b busy=%b, required 1 1 0", done0, pass0, busy0); end
        fault_mode = 1;
        launch(0, 20);
        follow(20, -1);
    endtask

    task automatic test_hold1();
        launch(1, 1);
        follow(1, -1);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_faulty();
        test_abort();
        test_restart();
        test_hold1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
